// File: rtl/swervolf_board_io_pkg.sv
// Shared constants and width helper for the SweRVolf board I/O front-end.
package swervolf_board_io_pkg;

   localparam int PWM_W = 8;
   localparam logic [PWM_W-1:0] PWM_FULL = 8'hFF;

   localparam int DEF_TICK_DIV  = 1000;
   localparam int DEF_DEB_TICKS = 8;

   // Ceiling log2, clamped to 1 so degenerate parameters still yield a legal vector width.
   function automatic int clog2_min1(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/swervolf_debounce.sv
// One switch channel: metastability chain, tick-driven debounce, and rise/fall event pulses.
module swervolf_debounce
   import swervolf_board_io_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_TICKS   = DEF_DEB_TICKS
) (
   input  logic clk,
   input  logic rstn,
   input  logic tick,
   input  logic sw_raw,
   output logic sw_level,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int CNT_W = clog2_min1(DEB_TICKS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   sw_sync;

   assign sw_sync = sync_q[SYNC_STAGES-1];

   // Any return to agreement discards progress; a new level is accepted on the tick that completes the run.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q   <= '0;
         cnt      <= '0;
         sw_level <= 1'b0;
         sw_rise  <= 1'b0;
         sw_fall  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_raw};
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
         if (sw_sync == sw_level) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt >= CNT_LAST) begin
               sw_level <= sw_sync;
               cnt      <= '0;
               sw_rise  <= sw_sync;
               sw_fall  <= ~sw_sync;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/swervolf_board_io.sv
// Board pin front-end: debounced switches with edge events, PWM-dimmed LEDs, idle-safe UART TX mux.
module swervolf_board_io
   import swervolf_board_io_pkg::*;
#(
   parameter int SW_WIDTH    = 16,
   parameter int LED_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int DEB_TICKS   = DEF_DEB_TICKS,
   parameter int UART_SRCS   = 2,
   parameter int SEL_W       = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [SW_WIDTH-1:0]  i_sw,
   output logic [SW_WIDTH-1:0]  o_sw,
   output logic [SW_WIDTH-1:0]  o_sw_rise,
   output logic [SW_WIDTH-1:0]  o_sw_fall,
   input  logic [LED_WIDTH-1:0] i_led,
   input  logic [PWM_W-1:0]     i_led_duty,
   output logic [LED_WIDTH-1:0] o_led,
   input  logic [UART_SRCS-1:0] i_uart_tx,
   input  logic [SEL_W-1:0]     i_uart_sel,
   output logic                 o_uart_tx
);

   localparam int PRESC_W = clog2_min1(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam int TX_PAD = 2 ** SEL_W;
   localparam logic [SEL_W:0] SRC_COUNT = (SEL_W + 1)'(UART_SRCS);

   logic [PRESC_W-1:0]   presc;
   logic                 tick;
   logic [PWM_W-1:0]     pwm;
   logic [LED_WIDTH-1:0] led_r;
   logic                 led_on;
   logic [SEL_W-1:0]     cur;
   logic [TX_PAD-1:0]    tx_pad;
   logic                 sel_ok;
   logic                 do_switch;

   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         presc <= '0;
      end else if (presc == PRESC_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
      swervolf_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_TICKS   (DEB_TICKS)
      ) u_debounce (
         .clk      (clk),
         .rstn     (rstn),
         .tick     (tick),
         .sw_raw   (i_sw[g]),
         .sw_level (o_sw[g]),
         .sw_rise  (o_sw_rise[g]),
         .sw_fall  (o_sw_fall[g])
      );
   end

   // Full duty bypasses the compare so 255 really means always on.
   assign led_on = (i_led_duty == PWM_FULL) || (pwm < i_led_duty);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pwm   <= '0;
         led_r <= '0;
         o_led <= '0;
      end else begin
         pwm   <= pwm + PWM_W'(1);
         led_r <= i_led;
         o_led <= led_r & {LED_WIDTH{led_on}};
      end
   end

   // Padding the TX vector to the select range keeps indexing legal; range is checked separately.
   assign tx_pad = TX_PAD'(i_uart_tx);

   always_comb begin
      sel_ok    = ({1'b0, i_uart_sel} < SRC_COUNT);
      do_switch = sel_ok && (i_uart_sel != cur) && tx_pad[cur] && tx_pad[i_uart_sel];
   end

   // Switching only while both lines idle high avoids chopping a frame on either source.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cur       <= '0;
         o_uart_tx <= 1'b1;
      end else begin
         o_uart_tx <= tx_pad[cur];
         if (do_switch) begin
            cur <= i_uart_sel;
         end
      end
   end

endmodule
